// File: rtl/tcp_pkg.sv
// Shared types for the transmit scheduler: command encodings, command structs,
// flow-table sizing and the scheduler FSM states.
package tcp_pkg;

   localparam int MAX_FLOW_CNT = 64;  // power of two so flow indices wrap by truncation
   localparam int FLOWID_W     = $clog2(MAX_FLOW_CNT);
   localparam int TS_W         = 16;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      SET   = 2'd1,
      CLEAR = 2'd2
   } sched_cmd_e;

   typedef struct packed {
      sched_cmd_e      cmd;
      logic [TS_W-1:0] timestamp;
   } set_clear_struct;

   typedef struct packed {
      logic [FLOWID_W-1:0] flowid;
      set_clear_struct     ack;
      set_clear_struct     data;
      set_clear_struct     rt;
   } sched_cmd_struct;

   typedef enum logic {
      SCAN = 1'b0,
      OUT  = 1'b1
   } sched_state_e;

   function automatic logic apply_cmd(input logic cur, input sched_cmd_e cmd);
      logic res;
      res = cur;
      case (cmd)
         SET:     res = 1'b1;
         CLEAR:   res = 1'b0;
         default: res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tx_sched_pend_table_if.sv
// Command inputs from RX/timeout producers and the dispatch channel to the TX engine.
interface tx_sched_pend_table_if;
   import tcp_pkg::*;

   logic                rx_tx_sched_cmd_val;
   sched_cmd_struct     rx_tx_sched_cmd_data;
   logic                tx_sched_rx_cmd_rdy;

   logic                tx_timeout_tx_sched_cmd_val;
   sched_cmd_struct     tx_timeout_tx_sched_cmd_data;
   logic                tx_sched_tx_timeout_cmd_rdy;

   logic                tx_sched_tx_eng_req_val;
   logic [FLOWID_W-1:0] tx_sched_tx_eng_req_flowid;
   logic [2:0]          tx_sched_tx_eng_req_pend;
   logic                tx_eng_tx_sched_req_rdy;

   modport master (
      output rx_tx_sched_cmd_val, rx_tx_sched_cmd_data,
      output tx_timeout_tx_sched_cmd_val, tx_timeout_tx_sched_cmd_data,
      output tx_eng_tx_sched_req_rdy,
      input  tx_sched_rx_cmd_rdy, tx_sched_tx_timeout_cmd_rdy,
      input  tx_sched_tx_eng_req_val, tx_sched_tx_eng_req_flowid, tx_sched_tx_eng_req_pend
   );

   modport slave (
      input  rx_tx_sched_cmd_val, rx_tx_sched_cmd_data,
      input  tx_timeout_tx_sched_cmd_val, tx_timeout_tx_sched_cmd_data,
      input  tx_eng_tx_sched_req_rdy,
      output tx_sched_rx_cmd_rdy, tx_sched_tx_timeout_cmd_rdy,
      output tx_sched_tx_eng_req_val, tx_sched_tx_eng_req_flowid, tx_sched_tx_eng_req_pend
   );

endinterface

// File: rtl/rr_first_set.sv
// Finds the first set bit of vec at or after start, wrapping around.
// Rotate so start lands at bit 0, priority-encode, then add start back.
module rr_first_set #(
   parameter  int WIDTH = 64,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [WIDTH-1:0] rot;
   logic [IDX_W-1:0] enc;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rot   = '0;
      enc   = '0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         rot[i] = vec[start + IDX_W'(i)];
      end
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc   = IDX_W'(i);
            found = 1'b1;
         end
      end
      idx = enc + start;
   end

endmodule

// File: rtl/tx_sched_pend_table.sv
// Per-flow ack/data/retransmit pending table with round-robin dispatch to the TX engine.
// Two-state FSM: SCAN captures a pending flow, OUT holds it until the engine accepts.
module tx_sched_pend_table #(
   parameter int MAX_FLOW_CNT = tcp_pkg::MAX_FLOW_CNT,
   parameter int FLOWID_W     = $clog2(MAX_FLOW_CNT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tx_sched_pend_table_if.slave  bus
);
   import tcp_pkg::*;

   sched_state_e            state_q, state_d;
   logic [MAX_FLOW_CNT-1:0] ack_pend, data_pend, rt_pend;
   logic [MAX_FLOW_CNT-1:0] ack_d, data_d, rt_d;
   logic [MAX_FLOW_CNT-1:0] any_pend;
   logic [FLOWID_W-1:0]     rr_ptr;
   logic [FLOWID_W-1:0]     out_flowid;
   logic [2:0]              out_pend;

   logic                    cmd_val;
   sched_cmd_struct         cmd;
   logic                    found;
   logic [FLOWID_W-1:0]     found_idx;
   logic                    capture;
   logic                    handshake;
   logic                    ts_unused;

   assign any_pend  = ack_pend | data_pend | rt_pend;
   assign capture   = (state_q == SCAN) && found;
   assign handshake = (state_q == OUT) && bus.tx_eng_tx_sched_req_rdy;

   // Timestamps travel with commands but do not affect the pending table.
   assign ts_unused = ^{bus.rx_tx_sched_cmd_data.ack.timestamp,
                        bus.rx_tx_sched_cmd_data.data.timestamp,
                        bus.rx_tx_sched_cmd_data.rt.timestamp,
                        bus.tx_timeout_tx_sched_cmd_data.ack.timestamp,
                        bus.tx_timeout_tx_sched_cmd_data.data.timestamp,
                        bus.tx_timeout_tx_sched_cmd_data.rt.timestamp};

   rr_first_set #(.WIDTH(MAX_FLOW_CNT)) u_rr_first_set (
      .vec   (any_pend),
      .start (rr_ptr),
      .found (found),
      .idx   (found_idx)
   );

   // RX pipeline wins; the timeout engine only gets through on idle RX cycles.
   always_comb begin
      cmd_val = 1'b0;
      cmd     = bus.rx_tx_sched_cmd_data;
      if (bus.rx_tx_sched_cmd_val) begin
         cmd_val = 1'b1;
      end else if (bus.tx_timeout_tx_sched_cmd_val) begin
         cmd_val = 1'b1;
         cmd     = bus.tx_timeout_tx_sched_cmd_data;
      end
   end

   // Dispatch clears first, then the command applies: a same-cycle SET survives the capture.
   always_comb begin
      ack_d  = ack_pend;
      data_d = data_pend;
      rt_d   = rt_pend;
      if (capture) begin
         ack_d[found_idx]  = 1'b0;
         data_d[found_idx] = 1'b0;
         rt_d[found_idx]   = 1'b0;
      end
      if (cmd_val) begin
         ack_d[cmd.flowid]  = apply_cmd(ack_d[cmd.flowid],  cmd.ack.cmd);
         data_d[cmd.flowid] = apply_cmd(data_d[cmd.flowid], cmd.data.cmd);
         rt_d[cmd.flowid]   = apply_cmd(rt_d[cmd.flowid],   cmd.rt.cmd);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCAN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:    if (found) state_d = OUT;
         OUT:     if (bus.tx_eng_tx_sched_req_rdy) state_d = SCAN;
         default: state_d = SCAN;
      endcase
   end

   // Outputs are gated by rst_n so everything reads 0 during the reset cycle itself.
   always_comb begin
      bus.tx_sched_rx_cmd_rdy         = rst_n;
      bus.tx_sched_tx_timeout_cmd_rdy = rst_n & ~bus.rx_tx_sched_cmd_val;
      bus.tx_sched_tx_eng_req_val     = 1'b0;
      bus.tx_sched_tx_eng_req_flowid  = '0;
      bus.tx_sched_tx_eng_req_pend    = '0;
      if (rst_n && (state_q == OUT)) begin
         bus.tx_sched_tx_eng_req_val    = 1'b1;
         bus.tx_sched_tx_eng_req_flowid = out_flowid;
         bus.tx_sched_tx_eng_req_pend   = out_pend;
      end
   end

   // NOTE: the pend vectors are plain flops, not a RAM, so they are reset explicitly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_pend   <= '0;
         data_pend  <= '0;
         rt_pend    <= '0;
         rr_ptr     <= '0;
         out_flowid <= '0;
         out_pend   <= '0;
      end else begin
         ack_pend  <= ack_d;
         data_pend <= data_d;
         rt_pend   <= rt_d;
         if (capture) begin
            out_flowid <= found_idx;
            out_pend   <= {ack_pend[found_idx], data_pend[found_idx], rt_pend[found_idx]};
         end
         if (handshake) begin
            rr_ptr <= out_flowid + FLOWID_W'(1);
         end
      end
   end

endmodule

// File: doc/tx_sched_pend_table.md
Name: tx_sched_pend_table

Overview:
- Transmit scheduler stage. Consumes set/clear commands from the RX pipeline and the retransmit-timeout engine.
- Holds three per-flow pending bits: ack, data and retransmit.
- Round-robin selects a flow with any pending bit and hands {flowid, pend bits} to the TX engine, clearing the bits it dispatched.
- Sits between the command producers and the TX header/payload engine.

Parameters:
- MAX_FLOW_CNT, 64, number of flows tracked; must be a power of two.
- FLOWID_W, $clog2(MAX_FLOW_CNT), flow index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- rx_tx_sched_cmd_val  in  1  RX-pipeline command valid (src0)
- rx_tx_sched_cmd_data  in  sched_cmd_struct  RX-pipeline command
- tx_sched_rx_cmd_rdy  out  1  src0 ready
- tx_timeout_tx_sched_cmd_val  in  1  timeout-engine command valid (src1)
- tx_timeout_tx_sched_cmd_data  in  sched_cmd_struct  timeout command
- tx_sched_tx_timeout_cmd_rdy  out  1  src1 ready
- tx_sched_tx_eng_req_val  out  1  dispatch valid
- tx_sched_tx_eng_req_flowid  out  FLOWID_W  dispatched flow
- tx_sched_tx_eng_req_pend  out  3  {ack, data, rt} pending snapshot
- tx_eng_tx_sched_req_rdy  in  1  TX engine ready

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low.
  - While rst_n=0: all pend vectors, rr_ptr and out regs go to 0; state=SCAN.
  - Outputs during reset: all outputs 0, including both cmd rdy signals.
- Command acceptance:
  - One command per cycle. src0 has fixed priority.
  - tx_sched_rx_cmd_rdy = 1 whenever not in reset.
  - tx_sched_tx_timeout_cmd_rdy = ~rx_tx_sched_cmd_val.
  - Accepted command updates the vectors at the next edge. For each of the three fields: SET sets bit[flowid], CLEAR clears it, NOP leaves it.
  - Timestamp fields are ignored.
- Pend vectors: ack_pend, data_pend and rt_pend, each MAX_FLOW_CNT flops. any_pend = OR of the three.
- FSM states: SCAN and OUT.
  - SCAN: search any_pend for the first set index starting at rr_ptr, wrapping modulo MAX_FLOW_CNT; the search is combinational.
    - If found: capture flowid and the 3 bits into out regs; clear those three bits for that flow at the same edge; go to OUT.
    - If none found: stay in SCAN.
  - OUT: req_val=1 with data stable.
    - When rdy=1: rr_ptr <= flowid+1, wrapping from MAX_FLOW_CNT-1 to 0; go to SCAN.
    - Hold indefinitely while rdy=0.
- Same-cycle collision (SCAN capture of flow F while an accepted command targets F):
  - The snapshot uses pre-command bits.
  - A SET in the command leaves that bit set after the edge, so it is dispatched again later.
  - A CLEAR or NOP on a bit being dispatched leaves it cleared.
- Commands to flows already dispatched but not yet handshaken just update the vectors; the out regs are unaffected.
- Latency:
  - Command accepted at edge N: bits visible in cycle N+1; earliest capture at edge N+1; req_val earliest in cycle N+1 after that capture.
  - End to end: 2 cycles minimum from command valid to req_val.
  - Back-to-back dispatch: one dispatch per 2 cycles (SCAN/OUT).
- Fairness: rr_ptr guarantees every pending flow is dispatched within MAX_FLOW_CNT dispatches.
- Reset mid-OUT: req_val drops on the reset cycle and the pending dispatch is lost.

Decomposition:
- tcp_pkg (shared): sched_cmd_struct, set_clear_struct {cmd, timestamp}, the sched_cmd_e enum {NOP, SET, CLEAR}, FLOWID_W, MAX_FLOW_CNT.
- Sub-module rr_first_set (WIDTH parameter): inputs vec and start index; outputs found and idx. The wrap-around search is done by rotate + priority encode + un-rotate.

Test Plan:
- Reset, then src0 SET data on flow 5, rdy=1 → req_val 2 cycles later with flowid=5, pend=3'b010; data_pend[5]=0 afterwards; no further req.
- SET ack on 3 and rt on 60, rr_ptr=0, rdy held low 10 cycles → flow 3 held stable with pend=3'b100 for all 10 cycles; after rdy, next dispatch is 60 with pend 3'b001, then idle.
- src0 and src1 valid on the same cycle (flows 7 and 9) → src0 accepted and src1 rdy=0 that cycle; src1 accepted the next cycle; dispatch order 7 then 9.
- Flow 63 pending with rr_ptr=63, dispatched → rr_ptr wraps to 0; then flows 0 and 62 pending → 0 dispatched before 62.
- Flow 4 captured in the same cycle as SET rt on flow 4 → first dispatch shows the pre-command bits; flow 4 is dispatched again with rt=1.
- rst_n low for 1 cycle while in OUT → req_val=0 the next cycle, all pend vectors 0, no dispatch until a new command arrives.
